// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
package seg_pkg;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam int unsigned NIBBLE_W  = 4;

endpackage

// File: rtl/seg_scan_ctrl_converter_7s.sv
// Hex nibble to active-low seven-segment pattern (gfedcba), purely combinational.
module converter_7s
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [6:0]          seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0010000;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b0000011;
            4'hC: seg_c = 7'b1000110;
            4'hD: seg_c = 7'b0100001;
            4'hE: seg_c = 7'b0000110;
            4'hF: seg_c = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with tear-free frame-boundary value updates.
// Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
    output logic [6:0]                     seg,
    output logic [NUM_DIGITS-1:0]          an,
    output logic                           frame_done
);

    localparam int unsigned VW      = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IW      = $clog2(NUM_DIGITS);

    scan_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  first_q, first_d;
    logic [VW-1:0]         display_q, display_d;
    logic [VW-1:0]         pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  wrap_c;
    logic                  lit_c;
    logic [NIBBLE_W-1:0]   nibble_c;
    logic [6:0]            conv_seg_c;

    // Scan sequencing plus pending/display hand-off at the frame wrap.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        first_d         = first_q;
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        wrap_c          = 1'b0;

        case (state_q)
            ST_SHOW: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    // The blank after reset leads straight into digit 0.
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d  = '0;
                        wrap_c = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        if (wrap_c) begin
            if (load) begin
                display_d = value;
            end else if (pending_valid_q) begin
                display_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_valid_d = 1'b1;
        end
        if (load) begin
            pending_d = value;
        end
    end

    always_comb begin
        nibble_c = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                nibble_c = display_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] top_c;

    // Highest nonzero nibble; digits above it stay dark.
    always_comb begin
        top_c = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (display_q[i*NIBBLE_W +: NIBBLE_W] != '0) begin
                top_c = IW'(i);
            end
        end
    end

    assign lit_c = (state_q == ST_SHOW) && (idx_q <= top_c);
`else
    assign lit_c = (state_q == ST_SHOW);
`endif

    converter_7s u_conv (
        .nibble (nibble_c),
        .seg_c  (conv_seg_c)
    );

    always_comb begin
        seg_d        = lit_c ? conv_seg_c : SEG_BLANK;
        an_d         = '1;
        frame_done_d = wrap_c;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            an_d[i] = !(lit_c && (idx_q == IW'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_BLANK;
            cnt_q           <= '0;
            idx_q           <= '0;
            first_q         <= 1'b1;
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= SEG_BLANK;
            an_q            <= '1;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            first_q         <= first_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, DIV=4, BLANK_CYCLES=2).
// Honours SEG_LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int D  = 4;
    localparam int B  = 2;
    localparam int P  = ND * (D + B);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: cycle index since reset release and display contents.
    int          c;
    logic [15:0] m_disp, m_pend;
    logic        m_pv;

    typedef struct packed {
        logic [15:0]     val;
        logic [3:0][6:0] segs;
        logic [3:0]      lit;
    } vec_t;

    vec_t tbl [5];

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(D), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Digit shown in cycle k, or -1 when all anodes are off.
    function automatic int show_digit(input int k);
        int r;
        if (k < B) return -1;
        r = (k - B) % P;
        if ((r % (D + B)) < D) return r / (D + B);
        return -1;
    endfunction

    function automatic bit wrap_start(input int k);
        return (k >= B + P) && (((k - B) % P) == 0);
    endfunction

    function automatic bit lit_digit(input int d, input logic [15:0] disp);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b1;
        for (int j = d; j < ND; j++) if (disp[j*4 +: 4] != 4'h0) return 1'b1;
        return 1'b0;
`else
        return (d >= 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, c);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: bound expired (cycle %0d)", name, c);
    endtask

    // One clock: drive inputs, predict the registered outputs, compare after the edge.
    task automatic step(input logic ld, input logic [15:0] v);
        int         dig;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ef;
        load  = ld;
        value = v;
        dig = show_digit(c);
        if (dig >= 0 && lit_digit(dig, m_disp)) begin
            es = hex7(m_disp[dig*4 +: 4]);
            ea = ~(4'b0001 << dig);
        end else begin
            es = 7'h7F;
            ea = 4'hF;
        end
        ef = wrap_start(c + 1);
        if (wrap_start(c + 1)) begin
            if (ld) m_disp = v;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else if (ld) begin
            m_pv = 1'b1;
        end
        if (ld) m_pend = v;
        @(posedge clk);
        #1;
        c++;
        load = 1'b0;
        check("seg", 32'(seg), 32'(es));
        check("an", 32'(an), 32'(ea));
        check("frame_done", 32'(frame_done), 32'(ef));
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (!wrap_start(c) && n < 60) begin
            step(1'b0, 16'h0);
            n++;
        end
        if (n >= 60) fail("wait_frame_start");
    endtask

    // Walk a whole frame, checking each digit mid-slot against table constants.
    task automatic check_frame(input string tag, input logic [3:0][6:0] segs, input logic [3:0] lit);
        logic [3:0] ea;
        int         d;
        for (int j = 0; j < P; j++) begin
            step(1'b0, 16'h0);
            if (j % (D + B) == 2) begin
                d  = j / (D + B);
                ea = lit[d] ? ~(4'b0001 << d) : 4'hF;
                check({tag, "_seg"}, 32'(seg), lit[d] ? 32'(segs[d]) : 32'h7F);
                check({tag, "_an"}, 32'(an), 32'(ea));
            end
        end
    endtask

    initial begin
        logic [3:0] lz05;
        int         n;
        int         last_fd;

`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz05 = 4'b0001;
        tbl[3] = '{val: 16'h0000, segs: {7'h40, 7'h40, 7'h40, 7'h40}, lit: 4'b0001};
        tbl[4] = '{val: 16'h0040, segs: {7'h40, 7'h40, 7'h19, 7'h40}, lit: 4'b0011};
`else
        lz05 = 4'b1111;
        tbl[3] = '{val: 16'h0000, segs: {7'h40, 7'h40, 7'h40, 7'h40}, lit: 4'b1111};
        tbl[4] = '{val: 16'h0040, segs: {7'h40, 7'h40, 7'h19, 7'h40}, lit: 4'b1111};
`endif
        tbl[0] = '{val: 16'h12AF, segs: {7'h79, 7'h24, 7'h08, 7'h0E}, lit: 4'b1111};
        tbl[1] = '{val: 16'h8C3E, segs: {7'h00, 7'h46, 7'h30, 7'h06}, lit: 4'b1111};
        tbl[2] = '{val: 16'h5D7B, segs: {7'h12, 7'h21, 7'h78, 7'h03}, lit: 4'b1111};

        rst_n  = 1'b0;
        load   = 1'b0;
        value  = 16'h0;
        c      = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_pv   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Power-up: one blank period, then digit 0 for DIV cycles.
        for (int j = 1; j <= 7; j++) begin
            step(1'b0, 16'h0);
            check("boot_an", 32'(an), (j >= 3 && j <= 6) ? 32'hE : 32'hF);
        end

        for (int t = 0; t < 5; t++) begin
            step(1'b1, tbl[t].val);
            wait_frame_start();
            check_frame($sformatf("tbl%0d", t), tbl[t].segs, tbl[t].lit);
        end

        // Two loads in one frame: only the later one reaches the display.
        step(1'b1, 16'h1111);
        repeat (3) step(1'b0, 16'h0);
        step(1'b1, 16'h2222);
        wait_frame_start();
        check_frame("latest_load", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

        // Load exactly on the wrap edge goes straight to the display.
        n = 0;
        while (!wrap_start(c + 1) && n < 60) begin
            step(1'b0, 16'h0);
            n++;
        end
        if (n >= 60) fail("wait_wrap_edge");
        step(1'b1, 16'h0005);
        check("wrap_load_pv", 32'(dut.pending_valid_q), 32'h0);
        check_frame("wrap_load", {7'h40, 7'h40, 7'h40, 7'h12}, lz05);

        // Reset in the middle of digit 2 with a pending value outstanding.
        step(1'b1, 16'hBEEF);
        n = 0;
        while (show_digit(c) != 2 && n < 60) begin
            step(1'b0, 16'h0);
            n++;
        end
        if (n >= 60) fail("wait_digit2");
        step(1'b0, 16'h0);
        rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_frame_done", 32'(frame_done), 32'h0);
        check("async_display", 32'(dut.display_q), 32'h0);
        check("async_pv", 32'(dut.pending_valid_q), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        c      = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_pv   = 1'b0;
        repeat (30) step(1'b0, 16'h0);

        // Random loads against the model, plus frame_done spacing.
        last_fd = -1;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(7) == 0) step(1'b1, 16'($urandom));
            else step(1'b0, 16'h0);
            if (frame_done) begin
                if (last_fd >= 0) check("frame_period", 32'(c - last_fd), 32'(P));
                last_fd = c;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter DIV, default 50000, clocks each digit is driven (at least 2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, clocks all anodes are off between digits (at least 1).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  in  1  single-cycle strobe capturing value.
REQ-007 SHALL have port value  in  4*NUM_DIGITS  hex digits, digit 0 in bits [3:0].
REQ-008 SHALL have port seg  out  7  segment pattern, active-low, gfedcba order.
REQ-009 SHALL have port an  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all-high.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse at frame wrap.

Function
REQ-011 SHALL use a two-state FSM: SHOW (one digit driven) and BLANK (all anodes off).
REQ-012 SHALL count DIV clocks in SHOW, then go to BLANK; count BLANK_CYCLES clocks in BLANK, then advance the digit index and return to SHOW.
REQ-013 SHALL wrap the digit index NUM_DIGITS-1 -> 0; frame_done SHALL pulse exactly one cycle on the wrap transition.
REQ-014 SHALL capture value into a pending register on load; pending_valid SHALL set on load.
REQ-015 SHALL copy pending into the display register only on the wrap transition when pending_valid is set, then clear pending_valid, so frames never tear.
REQ-016 SHALL, when load coincides with the wrap transition, transfer the newly loaded value directly and leave pending_valid clear.
REQ-017 SHALL honour only the latest load; multiple loads within one frame SHALL overwrite pending.
REQ-018 SHALL decode the selected nibble through the shared hex-to-7-segment converter.
REQ-019 SHALL register seg and an, giving one clock latency from FSM state to pins.
REQ-020 SHALL drive an all-high and seg = 7'h7F during BLANK.
REQ-021 SHALL drive an[i] low only in SHOW with index i.

Reset
REQ-022 SHALL, on rst_n low, immediately force state BLANK, digit index 0, counters 0, display and pending 0, pending_valid 0, an all-high, seg 7'h7F, frame_done 0.
REQ-023 SHALL, after rst_n release, complete one BLANK period (BLANK_CYCLES) and then show digit 0.
REQ-024 SHALL discard a partially shown frame and any pending value when reset asserts mid-operation.

Configuration
REQ-025 SHALL support macro SEG_LEADING_ZERO_BLANK_EN.
REQ-026 SHALL, with SEG_LEADING_ZERO_BLANK_EN defined, keep an all-high during SHOW for every digit above the highest nonzero display nibble; digit 0 SHALL always be shown; timing is unchanged.
REQ-027 SHALL, without the macro, show all NUM_DIGITS digits, including leading zeros.

Structure
REQ-028 SHALL take from shared package seg_pkg: the FSM state enum, SEG_BLANK = 7'h7F, and the digit nibble width constant (4).
REQ-029 SHALL instantiate exactly one converter_7s sub-module for decoding; no other sub-modules.

Verification (NUM_DIGITS=4, DIV=4, BLANK_CYCLES=2)
REQ-030 SHALL check: reset release -> an=4'b1111 for 2 cycles, then an=4'b1110 for 4 cycles, with one register-cycle latency.
REQ-031 SHALL check: load value=16'h12AF -> after next wrap, seg sequence F(0001110), A(0001000), 2(0100100), 1(1111001) on an 1110, 1101, 1011, 0111.
REQ-032 SHALL check: loads 16'h1111 then 16'h2222 within one frame -> only 2222 displayed next frame, no mixed digits.
REQ-033 SHALL check: load 16'h0005 on the wrap cycle -> 0005 shown in the frame starting that cycle; pending_valid=0.
REQ-034 SHALL check: rst_n low during digit 2 -> an=4'b1111, seg=7'h7F asynchronously, and display cleared to 0.
REQ-035 SHALL check: with SEG_LEADING_ZERO_BLANK_EN and value 16'h0005 -> only digit 0 ever lit; frame_done period still 24 cycles.
